// File: rtl/sw_ctrlr_xn.sv
// N-channel switch controller: synchronise, debounce and edge-detect
// switch pins; keeps sticky event/overrun flags and drives one IRQ.
module sw_ctrlr_xn #(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit IRQ_PULSE       = 1'b0
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic            enable_irq,
  input  logic [N_CH-1:0] sw_mask,
  input  logic [N_CH-1:0] edge_rise_en,
  input  logic [N_CH-1:0] edge_fall_en,
  input  logic [N_CH-1:0] sw_event_ack,
  output logic [N_CH-1:0] sw_event,
  output logic [N_CH-1:0] sw_overrun,
  output logic [N_CH-1:0] sw_state,
  output logic            irq,
  input  logic [N_CH-1:0] SW
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
  logic [N_CH-1:0]                  sync;
  logic [N_CH-1:0][CW-1:0]          cnt_q;
  logic [N_CH-1:0]                  state_q;
  logic [N_CH-1:0]                  state_d_q;
  logic [N_CH-1:0]                  ev_q;
  logic [N_CH-1:0]                  ev_d_q;
  logic [N_CH-1:0]                  ov_q;
  logic                             irq_q;
  logic [N_CH-1:0]                  rise;
  logic [N_CH-1:0]                  fall;
  logic [N_CH-1:0]                  cap;
  logic [N_CH-1:0]                  ev_nxt;
  logic [N_CH-1:0]                  ov_nxt;
  logic                             irq_nxt;

  assign sync = sync_q[SYNC_STAGES-1];

  // Synchroniser chain for the raw pins
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], SW};
    end
  end

  // Debounce: accept a new level once it has persisted long enough
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt_q   <= '0;
      state_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (sync[i] == state_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          state_q[i] <= sync[i];
          cnt_q[i]   <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // Edge qualification against the previous debounced level
  always_comb begin
    rise = state_q & ~state_d_q & edge_rise_en & ~sw_mask;
    fall = ~state_q & state_d_q & edge_fall_en & ~sw_mask;
    cap  = rise | fall;
  end

  // Sticky flag update; a fresh edge wins over a same-cycle ack
  always_comb begin
    ev_nxt = cap | (ev_q & ~sw_event_ack);
    ov_nxt = ~sw_event_ack & (ov_q | (cap & ev_q));
  end

  // Interrupt: level of pending flags, or one pulse per new flag set
  always_comb begin
    irq_nxt = 1'b0;
    if (IRQ_PULSE) begin
      irq_nxt = enable_irq & |(ev_q & ~ev_d_q);
    end else begin
      irq_nxt = enable_irq & |ev_q;
    end
  end

  // Flag, history and interrupt registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_d_q <= '0;
      ev_q      <= '0;
      ev_d_q    <= '0;
      ov_q      <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_d_q <= state_q;
      ev_q      <= ev_nxt;
      ev_d_q    <= ev_q;
      ov_q      <= ov_nxt;
      irq_q     <= irq_nxt;
    end
  end

  assign sw_event   = ev_q;
  assign sw_overrun = ov_q;
  assign sw_state   = state_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_sw_ctrlr_xn.sv
// Bench for sw_ctrlr_xn: level and pulse IRQ variants driven in parallel
// and compared every cycle against a behavioural model.
module tb_sw_ctrlr_xn;

  localparam int N   = 4;
  localparam int SS  = 2;
  localparam int DEB = 8;

  logic         aclk;
  logic         areset;
  logic         enable_irq;
  logic [N-1:0] sw_mask;
  logic [N-1:0] rise_en;
  logic [N-1:0] fall_en;
  logic [N-1:0] ack;
  logic [N-1:0] sw;
  logic [N-1:0] ev0, ov0, st0;
  logic [N-1:0] ev1, ov1, st1;
  logic         irq0, irq1;

  int total = 0;
  int bad   = 0;

  // model state
  logic [N-1:0] m_sync [SS];
  int           m_run  [N];
  logic [N-1:0] m_state, m_prev, m_ev, m_evp, m_ov;
  logic         m_irq0, m_irq1;

  sw_ctrlr_xn #(
    .N_CH(N), .SYNC_STAGES(SS),
    .DEBOUNCE_CYCLES(DEB), .IRQ_PULSE(1'b0)
  ) u_lvl (
    .aclk(aclk), .areset(areset), .enable_irq(enable_irq),
    .sw_mask(sw_mask), .edge_rise_en(rise_en),
    .edge_fall_en(fall_en), .sw_event_ack(ack),
    .sw_event(ev0), .sw_overrun(ov0), .sw_state(st0),
    .irq(irq0), .SW(sw)
  );

  sw_ctrlr_xn #(
    .N_CH(N), .SYNC_STAGES(SS),
    .DEBOUNCE_CYCLES(DEB), .IRQ_PULSE(1'b1)
  ) u_pls (
    .aclk(aclk), .areset(areset), .enable_irq(enable_irq),
    .sw_mask(sw_mask), .edge_rise_en(rise_en),
    .edge_fall_en(fall_en), .sw_event_ack(ack),
    .sw_event(ev1), .sw_overrun(ov1), .sw_state(st1),
    .irq(irq1), .SW(sw)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    for (int s = 0; s < SS; s++) m_sync[s] = '0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
    m_state = '0; m_prev = '0; m_ev = '0;
    m_evp = '0; m_ov = '0; m_irq0 = 0; m_irq1 = 0;
  endtask

  // advance model and DUTs by one clock, then compare everything
  task automatic tick();
    logic [N-1:0] ns, nev, nov, cap;
    logic         sb;
    ns = m_state; nev = m_ev; nov = m_ov; cap = '0;
    for (int i = 0; i < N; i++) begin
      sb = m_sync[SS-1][i];
      if (sb != m_state[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          ns[i] = sb;
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      cap[i] = ((m_state[i] && !m_prev[i] && rise_en[i]) ||
                (!m_state[i] && m_prev[i] && fall_en[i])) &&
               !sw_mask[i];
      if (cap[i] && ack[i]) begin
        nev[i] = 1; nov[i] = 0;
      end else if (cap[i] && m_ev[i]) begin
        nov[i] = 1;
      end else if (cap[i]) begin
        nev[i] = 1;
      end else if (ack[i]) begin
        nev[i] = 0; nov[i] = 0;
      end
    end
    m_irq0 = enable_irq && (m_ev != '0);
    m_irq1 = enable_irq && ((m_ev & ~m_evp) != '0);
    for (int s = SS - 1; s > 0; s--) m_sync[s] = m_sync[s-1];
    m_sync[0] = sw;
    m_prev = m_state; m_state = ns;
    m_evp = m_ev; m_ev = nev; m_ov = nov;
    @(posedge aclk);
    #1;
    chk("state_l", st0, m_state);
    chk("event_l", ev0, m_ev);
    chk("ovr_l", ov0, m_ov);
    chk("irq_l", irq0, m_irq0);
    chk("state_p", st1, m_state);
    chk("event_p", ev1, m_ev);
    chk("ovr_p", ov1, m_ov);
    chk("irq_p", irq1, m_irq1);
  endtask

  task automatic hold(int n);
    repeat (n) tick();
  endtask

  task automatic settle();
    sw = '0;
    hold(14);
    ack = '1;
    tick();
    ack = '0;
    hold(2);
  endtask

  initial begin
    int k;
    int p;
    areset = 1'b1; enable_irq = 1'b1;
    sw_mask = '0; rise_en = '1; fall_en = '0;
    ack = '0; sw = '0;
    mreset();
    #12;
    areset = 1'b0;
    chk("rst_state", st0, 0);
    chk("rst_event", ev0, 0);
    chk("rst_irq", irq0, 0);

    // latency of a clean press on ch0
    sw = 4'b0001;
    hold(9);
    chk("lat_state_e8", st0, 4'b0000);
    tick();
    chk("lat_state_e9", st0, 4'b0001);
    tick();
    chk("lat_event_e10", ev0, 4'b0001);
    chk("lat_irq_e10", irq0, 0);
    tick();
    chk("lat_irq_e11", irq0, 1);
    chk("lat_pulse_e11", irq1, 1);
    tick();
    chk("lat_pulse_e12", irq1, 0);
    ack = 4'b0001;
    tick();
    ack = '0;
    chk("ack_event", ev0, 4'b0000);
    tick();
    chk("ack_irq", irq0, 0);
    settle();

    // short glitches on ch1
    repeat (5) begin
      sw = 4'b0010; hold(7);
      sw = 4'b0000; hold(3);
    end
    hold(12);
    chk("glitch_state", st0, 4'b0000);
    chk("glitch_event", ev0, 4'b0000);
    chk("glitch_irq", irq0, 0);

    // two presses on ch2 without ack, then ack on a capture cycle
    repeat (2) begin
      sw = 4'b0100; hold(12);
      sw = 4'b0000; hold(12);
    end
    chk("ovr_event", ev0[2], 1);
    chk("ovr_flag", ov0[2], 1);
    sw = 4'b0100;
    k = 0;
    while (m_state[2] == 1'b0 && k < 40) begin
      tick(); k++;
    end
    chk("ovr_wait_ok", k < 40, 1);
    ack = 4'b0100;
    tick();
    ack = '0;
    chk("ackcap_event", ev0[2], 1);
    chk("ackcap_ovr", ov0[2], 0);
    settle();

    // falling-edge only on ch2
    rise_en = '0; fall_en = 4'b0100;
    sw = 4'b0100; hold(14);
    chk("fall_press", ev0, 4'b0000);
    sw = 4'b0000; hold(14);
    chk("fall_release", ev0, 4'b0100);
    settle();

    // all masked: state tracks, no events
    rise_en = '1; fall_en = '1; sw_mask = '1;
    sw = 4'b1111; hold(14);
    chk("mask_state", st0, 4'b1111);
    chk("mask_event", ev0, 4'b0000);
    sw = 4'b0000; hold(14);
    chk("mask_event2", ev0, 4'b0000);
    sw_mask = '0;
    settle();

    // pulse mode: simultaneous events give one pulse
    rise_en = '1; fall_en = '0;
    sw = 4'b1001;
    p = 0;
    repeat (20) begin tick(); p += int'(irq1); end
    chk("pulse_single", p, 1);
    chk("pulse_events", ev1, 4'b1001);
    fall_en = 4'b0001;
    sw = 4'b1000;
    p = 0;
    repeat (20) begin tick(); p += int'(irq1); end
    chk("pulse_ovr_none", p, 0);
    chk("pulse_ovr_flag", ov1[0], 1);
    enable_irq = 1'b0;
    ack = '1; tick(); ack = '0;
    sw = 4'b1010;
    hold(20);
    enable_irq = 1'b1;
    p = 0;
    repeat (5) begin tick(); p += int'(irq1); end
    chk("pulse_pending_none", p, 0);
    chk("level_pending", irq0, 1);
    settle();

    // randomized activity
    for (int r = 0; r < 40; r++) begin
      sw = 4'($urandom);
      if ($urandom_range(3) == 0) sw_mask = 4'($urandom);
      if ($urandom_range(3) == 0) rise_en = 4'($urandom);
      if ($urandom_range(3) == 0) fall_en = 4'($urandom);
      if ($urandom_range(5) == 0) enable_irq = ~enable_irq;
      for (int c = 0; c < int'($urandom_range(14, 1)); c++) begin
        ack = ($urandom_range(3) == 0) ? 4'($urandom) : 4'b0;
        tick();
      end
      ack = '0;
    end

    // async reset mid-debounce with flags pending
    sw_mask = '0; rise_en = '1; fall_en = '0; enable_irq = 1'b1;
    settle();
    sw = 4'b0001; hold(14);
    sw = 4'b1001; hold(SS + 5);
    #2 areset = 1'b1;
    #1;
    chk("arst_state", st0, 0);
    chk("arst_event", ev0, 0);
    chk("arst_ovr", ov0, 0);
    chk("arst_irq", irq0, 0);
    mreset();
    @(posedge aclk);
    #1 areset = 1'b0;
    k = 0;
    while (m_state[3] == 1'b0 && k < 40) begin
      tick(); k++;
    end
    chk("arst_rel_wait_ok", k < 40, 1);
    chk("arst_rel_state", st0, 4'b1001);
    hold(2);
    chk("arst_rel_event", ev0, 4'b1001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
